// File: rtl/sram_rw_sched.sv
// ============================================================================
// sram_rw_sched
// ----------------------------------------------------------------------------
// Purpose:
//   Sequences one single-port, way-masked, set-associative SRAM that can do
//   either one read or one write per cycle, with 1-cycle read latency.
//   After reset it sweeps every set and writes zero to all ways. It then
//   arbitrates between a read-request port and a write-request port.
//   Writes have priority. A read that has been blocked for STARVE_MAX
//   consecutive cycles is forced through, so reads cannot starve.
//
// Optional feature (compile-time macro SRAM_RW_SCHED_HOLD_RDATA_EN):
//   When defined, io_rresp_data is held stable from one read response to the
//   next. When undefined, io_rresp_data passes sram_rresp_data straight
//   through and is meaningful only while io_rresp_valid is high.
//
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-low reset
//   io_rreq_*               read request (valid/ready/setIdx)
//   io_rresp_*              read response (valid one cycle after accept)
//   io_wreq_*               write request (valid/ready/setIdx/data/waymask)
//   io_init_done            high once the zero-initialisation sweep is over
//   sram_rreq_*             read command towards the SRAM wrapper
//   sram_rresp_data         read data from the SRAM wrapper
//   sram_wreq_*             write command towards the SRAM wrapper
// Data packing: way w occupies bits [w*WIDTH +: WIDTH].
// ============================================================================
module sram_rw_sched #(
   parameter  int SETS       = 1024,
   parameter  int WAYS       = 8,
   parameter  int WIDTH      = 20,
   parameter  int STARVE_MAX = 4,
   localparam int IDXW       = $clog2(SETS),
   localparam int DW         = WAYS * WIDTH
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            io_rreq_valid,
   output logic            io_rreq_ready,
   input  logic [IDXW-1:0] io_rreq_setIdx,
   output logic            io_rresp_valid,
   output logic [DW-1:0]   io_rresp_data,
   input  logic            io_wreq_valid,
   output logic            io_wreq_ready,
   input  logic [IDXW-1:0] io_wreq_setIdx,
   input  logic [DW-1:0]   io_wreq_data,
   input  logic [WAYS-1:0] io_wreq_waymask,
   output logic            io_init_done,
   output logic            sram_rreq_valid,
   output logic [IDXW-1:0] sram_rreq_setIdx,
   input  logic [DW-1:0]   sram_rresp_data,
   output logic            sram_wreq_valid,
   output logic [IDXW-1:0] sram_wreq_setIdx,
   output logic [DW-1:0]   sram_wreq_data,
   output logic [WAYS-1:0] sram_wreq_waymask
);

   localparam int CNTW = $clog2(STARVE_MAX + 1);

   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   localparam logic [IDXW-1:0] LAST_SET  = IDXW'(SETS - 1);
   localparam logic [CNTW-1:0] STARVE_LIM = CNTW'(STARVE_MAX);

   logic [0:0]      state_q, state_d;
   logic [IDXW-1:0] init_ptr_q, init_ptr_d;
   logic [CNTW-1:0] starve_cnt_q, starve_cnt_d;
   logic            rresp_valid_q, rresp_valid_d;

   logic            force_rd;
   logic            rd_fire;
   logic            wr_fire;

   // Next-state and SRAM command generation. During the sweep the SRAM port
   // belongs to the initialiser and both requesters see ready low. In RUN the
   // SRAM index/data/mask follow the requesters; only the valids are gated by
   // the arbitration result, so at most one of them is ever high.
   always_comb begin
      state_d           = state_q;
      init_ptr_d        = init_ptr_q;
      starve_cnt_d      = starve_cnt_q;
      force_rd          = 1'b0;
      rd_fire           = 1'b0;
      wr_fire           = 1'b0;
      io_rreq_ready     = 1'b0;
      io_wreq_ready     = 1'b0;
      sram_rreq_valid   = 1'b0;
      sram_rreq_setIdx  = io_rreq_setIdx;
      sram_wreq_valid   = 1'b0;
      sram_wreq_setIdx  = io_wreq_setIdx;
      sram_wreq_data    = io_wreq_data;
      sram_wreq_waymask = io_wreq_waymask;

      case (state_q)
         ST_INIT: begin
            sram_wreq_valid   = 1'b1;
            sram_wreq_setIdx  = init_ptr_q;
            sram_wreq_data    = '0;
            sram_wreq_waymask = '1;
            init_ptr_d        = init_ptr_q + IDXW'(1);
            if (init_ptr_q == LAST_SET) begin
               state_d = ST_RUN;
            end
         end
         default: begin
            // A read that has waited STARVE_MAX cycles wins over any write.
            force_rd        = (starve_cnt_q == STARVE_LIM) && io_rreq_valid;
            io_wreq_ready   = ~force_rd;
            io_rreq_ready   = ~io_wreq_valid | force_rd;
            wr_fire         = io_wreq_valid & io_wreq_ready;
            rd_fire         = io_rreq_valid & io_rreq_ready;
            sram_wreq_valid = wr_fire;
            sram_rreq_valid = rd_fire;

            // Counts only cycles where a pending read actually lost to a write.
            if (rd_fire) begin
               starve_cnt_d = '0;
            end else if (io_rreq_valid && io_wreq_valid && (starve_cnt_q != STARVE_LIM)) begin
               starve_cnt_d = starve_cnt_q + CNTW'(1);
            end
         end
      endcase

      rresp_valid_d = rd_fire;
   end

   // State registers; reset restarts the sweep from set 0 at any time.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_INIT;
         init_ptr_q    <= '0;
         starve_cnt_q  <= '0;
         rresp_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         init_ptr_q    <= init_ptr_d;
         starve_cnt_q  <= starve_cnt_d;
         rresp_valid_q <= rresp_valid_d;
      end
   end

   assign io_init_done   = (state_q == ST_RUN);
   assign io_rresp_valid = rresp_valid_q;

`ifdef SRAM_RW_SCHED_HOLD_RDATA_EN
   logic [DW-1:0] hold_q, hold_d;

   // Capture each response so the data stays put until the next one.
   always_comb begin
      hold_d        = rresp_valid_q ? sram_rresp_data : hold_q;
      io_rresp_data = rresp_valid_q ? sram_rresp_data : hold_q;
   end

   // Hold register for the last read response.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         hold_q <= '0;
      end else begin
         hold_q <= hold_d;
      end
   end
`else
   assign io_rresp_data = sram_rresp_data;
`endif

endmodule

// File: tb/tb_sram_rw_sched.sv
// ============================================================================
// tb_sram_rw_sched
// ----------------------------------------------------------------------------
// Bench for sram_rw_sched. Contains a behavioural single-port SRAM (random
// contents at power-up, random read data on idle cycles) and a reference
// model that keeps a golden copy of every set plus a count of how long the
// current read has been waiting.
// ============================================================================
module tb_sram_rw_sched;

   localparam int SETS       = 1024;
   localparam int WAYS       = 8;
   localparam int WIDTH      = 20;
   localparam int STARVE_MAX = 4;
   localparam int IDXW       = $clog2(SETS);
   localparam int DW         = WAYS * WIDTH;

   logic            clock;
   logic            reset;
   logic            io_rreq_valid;
   logic            io_rreq_ready;
   logic [IDXW-1:0] io_rreq_setIdx;
   logic            io_rresp_valid;
   logic [DW-1:0]   io_rresp_data;
   logic            io_wreq_valid;
   logic            io_wreq_ready;
   logic [IDXW-1:0] io_wreq_setIdx;
   logic [DW-1:0]   io_wreq_data;
   logic [WAYS-1:0] io_wreq_waymask;
   logic            io_init_done;
   logic            sram_rreq_valid;
   logic [IDXW-1:0] sram_rreq_setIdx;
   logic [DW-1:0]   sram_rresp_data;
   logic            sram_wreq_valid;
   logic [IDXW-1:0] sram_wreq_setIdx;
   logic [DW-1:0]   sram_wreq_data;
   logic [WAYS-1:0] sram_wreq_waymask;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state
   bit            run_m;
   int            starve_m;
   logic [DW-1:0] gold [SETS];
   bit            pend_v;
   logic [DW-1:0] pend_d;

   // Behavioural SRAM contents
   logic [DW-1:0] mem [SETS];

   typedef struct {
      bit            rr;
      bit            wr;
      bit            rvalid;
      logic [DW-1:0] rdata;
   } samp_t;

   typedef struct {
      bit rv;
      bit wv;
      bit exp_rr;
      bit exp_wr;
   } vec_t;

   sram_rw_sched #(
      .SETS(SETS), .WAYS(WAYS), .WIDTH(WIDTH), .STARVE_MAX(STARVE_MAX)
   ) dut (
      .clock(clock),
      .reset(reset),
      .io_rreq_valid(io_rreq_valid),
      .io_rreq_ready(io_rreq_ready),
      .io_rreq_setIdx(io_rreq_setIdx),
      .io_rresp_valid(io_rresp_valid),
      .io_rresp_data(io_rresp_data),
      .io_wreq_valid(io_wreq_valid),
      .io_wreq_ready(io_wreq_ready),
      .io_wreq_setIdx(io_wreq_setIdx),
      .io_wreq_data(io_wreq_data),
      .io_wreq_waymask(io_wreq_waymask),
      .io_init_done(io_init_done),
      .sram_rreq_valid(sram_rreq_valid),
      .sram_rreq_setIdx(sram_rreq_setIdx),
      .sram_rresp_data(sram_rresp_data),
      .sram_wreq_valid(sram_wreq_valid),
      .sram_wreq_setIdx(sram_wreq_setIdx),
      .sram_wreq_data(sram_wreq_data),
      .sram_wreq_waymask(sram_wreq_waymask)
   );

   // 100 MHz free-running clock.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [DW-1:0] rand_data();
      logic [DW-1:0] d;
      for (int k = 0; k < WAYS; k++) begin
         d[k*WIDTH +: WIDTH] = WIDTH'($urandom());
      end
      return d;
   endfunction

   // Single-port SRAM: 1-cycle read latency, masked writes, and random
   // garbage on the read bus whenever no read was issued.
   always @(posedge clock) begin
      if (sram_rreq_valid) begin
         sram_rresp_data <= mem[sram_rreq_setIdx];
      end else begin
         sram_rresp_data <= rand_data();
      end
      if (sram_wreq_valid) begin
         for (int w = 0; w < WAYS; w++) begin
            if (sram_wreq_waymask[w]) begin
               mem[sram_wreq_setIdx][w*WIDTH +: WIDTH] = sram_wreq_data[w*WIDTH +: WIDTH];
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Hold reset for a cycle with both requests pending and check the
   // reset-time outputs, then release just after a rising edge.
   task automatic doReset();
      reset         = 1'b0;
      io_rreq_valid = 1'b1;
      io_wreq_valid = 1'b1;
      @(negedge clock);
      checkOutput("rst_init_done",   DW'(io_init_done),     '0);
      checkOutput("rst_rresp_valid", DW'(io_rresp_valid),   '0);
      checkOutput("rst_rreq_ready",  DW'(io_rreq_ready),    '0);
      checkOutput("rst_wreq_ready",  DW'(io_wreq_ready),    '0);
      checkOutput("rst_sweep_idx",   DW'(sram_wreq_setIdx), '0);
      checkOutput("rst_sram_rv",     DW'(sram_rreq_valid),  '0);
      @(posedge clock);
      #1;
      reset = 1'b1;
   endtask

   // Checks n cycles of the initialisation sweep while both requesters
   // hammer the ports with random requests that must all be ignored.
   task automatic checkSweep(input int n);
      for (int i = 0; i < n; i++) begin
         io_rreq_valid   = 1'b1;
         io_wreq_valid   = 1'b1;
         io_rreq_setIdx  = IDXW'($urandom());
         io_wreq_setIdx  = IDXW'($urandom());
         io_wreq_data    = rand_data();
         io_wreq_waymask = WAYS'($urandom());
         @(negedge clock);
         checkOutput("init_done_low", DW'(io_init_done),      '0);
         checkOutput("init_rready",   DW'(io_rreq_ready),     '0);
         checkOutput("init_wready",   DW'(io_wreq_ready),     '0);
         checkOutput("init_sram_wv",  DW'(sram_wreq_valid),   DW'(1));
         checkOutput("init_sram_idx", DW'(sram_wreq_setIdx),  DW'(i));
         checkOutput("init_sram_wd",  sram_wreq_data,         '0);
         checkOutput("init_sram_msk", DW'(sram_wreq_waymask), DW'(8'hFF));
         checkOutput("init_sram_rv",  DW'(sram_rreq_valid),   '0);
         checkOutput("init_rresp_v",  DW'(io_rresp_valid),    '0);
         @(posedge clock);
         #1;
      end
   endtask

   task automatic modelClear();
      run_m    = 1'b1;
      starve_m = 0;
      pend_v   = 1'b0;
      pend_d   = '0;
      for (int s = 0; s < SETS; s++) gold[s] = '0;
   endtask

   // One RUN-phase cycle: drive the requests, predict the outcome from the
   // arbitration rules, compare at the falling edge, then advance the model.
   task automatic applyStimulus(input bit rv, input logic [IDXW-1:0] ridx,
                                input bit wv, input logic [IDXW-1:0] widx,
                                input logic [DW-1:0] wdata, input logic [WAYS-1:0] wmask,
                                output samp_t s);
      bit read_starved, exp_rr, exp_wr, rfire, wfire;
      io_rreq_valid   = rv;
      io_rreq_setIdx  = ridx;
      io_wreq_valid   = wv;
      io_wreq_setIdx  = widx;
      io_wreq_data    = wdata;
      io_wreq_waymask = wmask;

      // Read gets the port if nobody writes, or if it has waited long enough.
      read_starved = run_m && (starve_m >= STARVE_MAX) && rv;
      exp_wr       = run_m && !read_starved;
      exp_rr       = run_m && (!wv || read_starved);
      wfire        = wv && exp_wr;
      rfire        = rv && exp_rr;

      @(negedge clock);
      s.rr     = io_rreq_ready;
      s.wr     = io_wreq_ready;
      s.rvalid = io_rresp_valid;
      s.rdata  = io_rresp_data;
      checkOutput("init_done",   DW'(io_init_done),    DW'(run_m));
      checkOutput("rreq_ready",  DW'(io_rreq_ready),   DW'(exp_rr));
      checkOutput("wreq_ready",  DW'(io_wreq_ready),   DW'(exp_wr));
      checkOutput("sram_rv",     DW'(sram_rreq_valid), DW'(rfire));
      checkOutput("sram_wv",     DW'(sram_wreq_valid), DW'(wfire));
      checkOutput("rresp_valid", DW'(io_rresp_valid),  DW'(pend_v));
      if (pend_v) checkOutput("rresp_data", io_rresp_data, pend_d);
      if (rfire) checkOutput("sram_ridx", DW'(sram_rreq_setIdx), DW'(ridx));
      if (wfire) begin
         checkOutput("sram_widx", DW'(sram_wreq_setIdx),  DW'(widx));
         checkOutput("sram_wd",   sram_wreq_data,         wdata);
         checkOutput("sram_wmsk", DW'(sram_wreq_waymask), DW'(wmask));
      end

      pend_v = rfire;
      if (rfire) pend_d = gold[ridx];
      if (wfire) begin
         for (int w = 0; w < WAYS; w++) begin
            if (wmask[w]) gold[widx][w*WIDTH +: WIDTH] = wdata[w*WIDTH +: WIDTH];
         end
      end
      if (rfire) starve_m = 0;
      else if (run_m && rv && wv && starve_m < STARVE_MAX) starve_m = starve_m + 1;

      @(posedge clock);
      #1;
   endtask

   // Main test sequence.
   initial begin
      vec_t          tbl [20];
      samp_t         s;
      logic [DW-1:0] wd;
      logic [DW-1:0] exp_c;
      logic [DW-1:0] hold_exp;

      tbl = '{
         '{1,1,0,1}, '{1,1,0,1}, '{1,1,0,1}, '{1,1,0,1}, '{1,1,1,0},
         '{1,1,0,1}, '{1,1,0,1}, '{1,1,0,1}, '{1,1,0,1}, '{1,1,1,0},
         '{1,1,0,1}, '{1,0,1,1}, '{0,1,0,1}, '{1,1,0,1}, '{0,0,1,1},
         '{1,1,0,1}, '{1,1,0,1}, '{1,1,0,1}, '{0,1,0,1}, '{1,1,1,0}
      };

      for (int i = 0; i < SETS; i++) mem[i] = rand_data();
      run_m           = 1'b0;
      starve_m        = 0;
      pend_v          = 1'b0;
      pend_d          = '0;
      io_rreq_setIdx  = '0;
      io_wreq_setIdx  = '0;
      io_wreq_data    = '0;
      io_wreq_waymask = '0;

      doReset();
      checkSweep(SETS);
      modelClear();

      // Masked write to set 3, then read it back on the following cycle.
      wd = rand_data();
      wd[2*WIDTH +: WIDTH] = 20'hABCDE;
      exp_c = '0;
      exp_c[2*WIDTH +: WIDTH] = 20'hABCDE;
      applyStimulus(1'b0, '0, 1'b1, IDXW'(3), wd, 8'h04, s);
      applyStimulus(1'b1, IDXW'(3), 1'b0, '0, rand_data(), '0, s);
      applyStimulus(1'b0, '0, 1'b0, '0, rand_data(), '0, s);
      checkOutput("wr_rd_valid", DW'(s.rvalid), DW'(1));
      checkOutput("wr_rd_data",  s.rdata,       exp_c);

      // Arbitration table: 4 writes then a forced read, repeated, followed by
      // the simultaneous-request and hold-without-read cases.
      for (int i = 0; i < 20; i++) begin
         applyStimulus(tbl[i].rv, IDXW'(10 + i % 4), tbl[i].wv, IDXW'(20 + i % 4),
                       rand_data(), WAYS'($urandom()), s);
         checkOutput($sformatf("tbl%0d_rready", i), DW'(s.rr), DW'(tbl[i].exp_rr));
         checkOutput($sformatf("tbl%0d_wready", i), DW'(s.wr), DW'(tbl[i].exp_wr));
      end

      // Randomised traffic over a small set range so reads hit recent writes.
      for (int i = 0; i < 400; i++) begin
         applyStimulus($urandom_range(99) < 65, IDXW'($urandom_range(15)),
                       $urandom_range(99) < 65, IDXW'($urandom_range(15)),
                       rand_data(), WAYS'($urandom()), s);
      end

`ifdef SRAM_RW_SCHED_HOLD_RDATA_EN
      hold_exp = gold[3];
      applyStimulus(1'b1, IDXW'(3), 1'b0, '0, rand_data(), '0, s);
      applyStimulus(1'b0, '0, 1'b0, '0, rand_data(), '0, s);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b0, '0, 1'b0, '0, rand_data(), '0, s);
         checkOutput($sformatf("hold%0d_data", i), s.rdata, hold_exp);
      end
`else
      hold_exp = '0;
      applyStimulus(1'b0, '0, 1'b0, '0, hold_exp, '0, s);
`endif

      // Reset in the middle of a sweep restarts it from set 0.
      run_m = 1'b0;
      doReset();
      checkSweep(500);
      doReset();
      checkSweep(SETS);
      modelClear();
      applyStimulus(1'b0, '0, 1'b0, '0, rand_data(), '0, s);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
